// File: rtl/period_meter_if.sv
// period_meter_if: the measured input plus the measurement results of period_meter.
// master is the meter itself; slave is whoever drives sig_in and reads the results.
interface period_meter_if #(
  parameter int CNT_W = 27
) ();
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] avg_period;

  modport master (
    input  sig_in,
    output period, high_time, valid, timeout, avg_period
  );

  modport slave (
    output sig_in,
    input  period, high_time, valid, timeout, avg_period
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: synchronises an async level input and reports its period/high time in clocks.
// Optional macro PERIOD_AVG_EN adds a 4-period running average on avg_period.
module period_meter #(
  parameter int          CNT_W       = 27,
  parameter int unsigned TIMEOUT     = 100_000_000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  period_meter_if.master bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    MEAS
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   sig_s;
  logic                   rise;
  logic                   fall;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_cap_reg, hi_cap_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             valid_reg, valid_next;
  logic             timeout_reg, timeout_next;
  logic             publish;
  logic             expire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], bus.sig_in};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_reg[SYNC_STAGES-1];
  assign rise  = sig_s & ~prev_reg;
  assign fall  = ~sig_s & prev_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hi_cap_reg  <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hi_cap_reg  <= hi_cap_next;
      period_reg  <= period_next;
      high_reg    <= high_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  // A rise always wins over an expiring count, so a period of exactly TIMEOUT is reported.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_cap_next  = hi_cap_reg;
    period_next  = period_reg;
    high_next    = high_reg;
    valid_next   = 1'b0;
    timeout_next = timeout_reg;
    publish      = 1'b0;
    expire       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next   = MEAS;
          cnt_next     = ONE;
          timeout_next = 1'b0;
        end
      end
      MEAS: begin
        if (rise) begin
          period_next = cnt_reg;
          high_next   = hi_cap_reg;
          valid_next  = 1'b1;
          cnt_next    = ONE;
          publish     = 1'b1;
        end else if (cnt_reg == TIMEOUT_C) begin
          timeout_next = 1'b1;
          period_next  = '0;
          high_next    = '0;
          hi_cap_next  = '0;
          cnt_next     = '0;
          state_next   = IDLE;
          expire       = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE;
          if (fall) begin
            hi_cap_next = cnt_reg;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.period    = period_reg;
  assign bus.high_time = high_reg;
  assign bus.valid     = valid_reg;
  assign bus.timeout   = timeout_reg;

`ifdef PERIOD_AVG_EN
  logic [CNT_W-1:0] hist_reg  [4];
  logic [CNT_W-1:0] hist_next [4];
  logic [CNT_W+1:0] sum_reg, sum_next;
  logic [2:0]       fill_reg, fill_next;
  logic [CNT_W-1:0] avg_reg;

  // Unfilled slots hold zero, so subtracting the oldest entry is always correct.
  assign sum_next  = sum_reg + {2'b00, cnt_reg} - {2'b00, hist_reg[3]};
  assign fill_next = (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;

  for (genvar gi = 0; gi < 4; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_next[gi] = cnt_reg;
    end else begin : g_tail
      assign hist_next[gi] = hist_reg[gi-1];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) hist_reg[i] <= '0;
      sum_reg  <= '0;
      fill_reg <= '0;
      avg_reg  <= '0;
    end else if (expire) begin
      for (int i = 0; i < 4; i++) hist_reg[i] <= '0;
      sum_reg  <= '0;
      fill_reg <= '0;
      avg_reg  <= '0;
    end else if (publish) begin
      hist_reg <= hist_next;
      sum_reg  <= sum_next;
      fill_reg <= fill_next;
      if (fill_next == 3'd4) begin
        avg_reg <= sum_next[CNT_W+1:2];
      end
    end
  end

  assign bus.avg_period = avg_reg;
`else
  assign bus.avg_period = period_reg;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter (TIMEOUT=100, CNT_W=8, SYNC_STAGES=2).
// Expected averages follow PERIOD_AVG_EN when the bench is built with it.
module tb_period_meter;
  localparam int CNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  period_meter_if #(.CNT_W(CNT_W)) bus ();

  period_meter #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (100),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int               vcount      = 0;
  int               dbl         = 0;
  logic             vprev       = 1'b0;
  logic [CNT_W-1:0] last_period = '0;
  logic [CNT_W-1:0] last_high   = '0;
  logic [CNT_W-1:0] last_avg    = '0;

  // Capture every valid strobe and count back-to-back strobes.
  always @(negedge clk) begin
    if (bus.valid) begin
      vcount      <= vcount + 1;
      last_period <= bus.period;
      last_high   <= bus.high_time;
      last_avg    <= bus.avg_period;
      if (vprev) dbl <= dbl + 1;
    end
    vprev <= bus.valid;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("[%0t] check %s observed=%0d expected=%0d", $time, tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int hi, input int lo);
    bus.sig_in = 1'b1;
    repeat (hi) tick();
    bus.sig_in = 1'b0;
    repeat (lo) tick();
  endtask

  int half     [6] = '{10, 10, 12, 12, 14, 10};
  int exp_per  [5] = '{20, 20, 24, 24, 28};
`ifdef PERIOD_AVG_EN
  int exp_avg  [5] = '{0, 0, 0, 22, 24};
`else
  int exp_avg  [5] = '{20, 20, 24, 24, 28};
`endif

  initial begin
    int base;
    int n;

    // Reset state
    bus.sig_in = 1'b0;
    reset      = 1'b0;
    repeat (3) tick();
    check("rst period",    32'(bus.period),     0);
    check("rst high_time", 32'(bus.high_time),  0);
    check("rst valid",     32'(bus.valid),      0);
    check("rst timeout",   32'(bus.timeout),    0);
    check("rst avg",       32'(bus.avg_period), 0);
    reset = 1'b1;
    tick();

    // Steady 10 high / 15 low
    base = vcount;
    drive(10, 15);
    check("t1 arm no valid", 32'(vcount), 32'(base));
    check("t1 timeout low",  32'(bus.timeout), 0);
    drive(10, 15);
    check("t1 valid count 1", 32'(vcount), 32'(base + 1));
    check("t1 period",        32'(last_period), 25);
    check("t1 high_time",     32'(last_high), 10);
    drive(10, 15);
    check("t1 valid count 2", 32'(vcount), 32'(base + 2));
    check("t1 period 2",      32'(last_period), 25);
    check("t1 timeout",       32'(bus.timeout), 0);

    // Toggle every clock: minimum period
    base = vcount;
    for (int i = 0; i < 20; i++) begin
      bus.sig_in = ~bus.sig_in;
      tick();
    end
    repeat (3) tick();
    check("t2 valid count", 32'(vcount), 32'(base + 10));
    check("t2 period",      32'(last_period), 2);
    check("t2 high_time",   32'(last_high), 1);

    // Timeout after 100 cycles with no rise
    drive(10, 15);
    drive(10, 15);
    check("t3 period before", 32'(last_period), 25);
    base = vcount;
    n    = 25;
    while (!bus.timeout && n < 300) begin
      tick();
      n++;
    end
    check("t3 timeout latency", 32'(n), 103);
    check("t3 timeout",         32'(bus.timeout), 1);
    check("t3 period cleared",  32'(bus.period), 0);
    check("t3 high cleared",    32'(bus.high_time), 0);
    check("t3 avg cleared",     32'(bus.avg_period), 0);
    check("t3 no valid",        32'(vcount), 32'(base));
    drive(10, 15);
    check("t3 rearm no valid",  32'(vcount), 32'(base));
    check("t3 rearm timeout",   32'(bus.timeout), 0);
    drive(10, 15);
    check("t3 resume valid",    32'(vcount), 32'(base + 1));
    check("t3 resume period",   32'(last_period), 25);

    // Async reset mid-period
    bus.sig_in = 1'b1;
    repeat (10) tick();
    bus.sig_in = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("t4 async period",  32'(bus.period), 0);
    check("t4 async high",    32'(bus.high_time), 0);
    check("t4 async valid",   32'(bus.valid), 0);
    check("t4 async timeout", 32'(bus.timeout), 0);
    check("t4 async avg",     32'(bus.avg_period), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (12) tick();
    base = vcount;
    drive(10, 15);
    check("t4 arm no valid", 32'(vcount), 32'(base));
    drive(10, 15);
    check("t4 valid",        32'(vcount), 32'(base + 1));
    check("t4 period",       32'(last_period), 25);

    // Period history: 20,20,24,24,28
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    base = vcount;
    drive(half[0], half[0]);
    check("t5 arm no valid", 32'(vcount), 32'(base));
    for (int k = 1; k < 6; k++) begin
      drive(half[k], half[k]);
      check($sformatf("t5 valid %0d", k),  32'(vcount), 32'(base + k));
      check($sformatf("t5 period %0d", k), 32'(last_period), 32'(exp_per[k-1]));
      check($sformatf("t5 high %0d", k),   32'(last_high), 32'(exp_per[k-1] / 2));
      check($sformatf("t5 avg %0d", k),    32'(last_avg), 32'(exp_avg[k-1]));
    end

    // Period of exactly TIMEOUT: the rise wins
    drive(50, 50);
    check("t6 period 20", 32'(last_period), 20);
    base = vcount;
    drive(50, 50);
    check("t6 valid",   32'(vcount), 32'(base + 1));
    check("t6 period",  32'(last_period), 100);
    check("t6 high",    32'(last_high), 50);
    check("t6 timeout", 32'(bus.timeout), 0);

    check("valid never doubled", 32'(dbl), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
